// File: rtl/iram_arbiter.sv
// iram_arbiter
// Shares the single-port instruction RAM between the CPU fetch stage (read)
// and the program loader (write). Every RAM access is sequenced here. The
// block absorbs the RAM's one-cycle synchronous read latency and flags
// out-of-range addresses.
// Optional feature: define IRAM_ARB_ROUND_ROBIN_EN to replace fixed loader
// priority with round-robin arbitration between loader and fetch.
//
// Handshake: a request (fetch_req / load_req) is held, with its address and
// data, until the matching *_ready is seen high. It is accepted on the
// rising edge where req && ready. Ready is combinational and is high only
// in IDLE, and only for the requester that wins arbitration. A request that
// is still held after acceptance counts as a new request. fetch_valid,
// load_done and addr_err are single-cycle registered pulses.
module iram_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 11,
    parameter int INSTRUCTION_WIDTH = 33,
    parameter int NUM_ADDRESS       = 1500
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_instr,
    input  logic                         load_req,
    input  logic [ADDRESS_BUS_WIDTH-1:0] load_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         addr_err,
    output logic [ADDRESS_BUS_WIDTH-1:0] iram_address,
    inout  wire  [INSTRUCTION_WIDTH-1:0] iram_data,
    output logic                         iram_read_not_write,
    output logic                         busy
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;
    // One extra bit so a limit equal to 2**AW is still representable.
    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(NUM_ADDRESS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        READ_RSP = 2'd2,
        WRITE    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rnw_q, rnw_d;
    logic [IW-1:0] wdata_q, wdata_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic          load_done_q, load_done_d;
    logic          addr_err_q, addr_err_d;
    // Set while the accepted access targets an out-of-range address. READ
    // and WRITE then just spend one cycle reporting the error and make no
    // RAM access.
    logic          err_q, err_d;
    logic          prefer_load;
    logic          fetch_oob;
    logic          load_oob;

    assign fetch_oob = ({1'b0, fetch_addr} >= ADDR_LIMIT);
    assign load_oob  = ({1'b0, load_addr} >= ADDR_LIMIT);

`ifdef IRAM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d; // 1 = loader won the most recent grant

    // Track the most recent winner so a contended cycle favours the other side.
    always_comb begin
        last_grant_d = last_grant_q;
        if (load_ready) begin
            last_grant_d = 1'b1;
        end else if (fetch_ready) begin
            last_grant_d = 1'b0;
        end
    end

    // Last-grant register; after reset, fetch counts as the last winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign prefer_load = ~last_grant_q;
`else
    assign prefer_load = 1'b1;
`endif

    // Arbitration, next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rnw_d         = rnw_q;
        wdata_d       = wdata_q;
        instr_d       = instr_q;
        err_d         = err_q;
        fetch_valid_d = 1'b0;
        load_done_d   = 1'b0;
        addr_err_d    = 1'b0;
        fetch_ready   = 1'b0;
        load_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready  = load_req && (!fetch_req || prefer_load);
                fetch_ready = fetch_req && !load_ready;
                if (load_ready) begin
                    state_d = WRITE;
                    err_d   = load_oob;
                    if (!load_oob) begin
                        addr_d  = load_addr;
                        rnw_d   = 1'b0;
                        wdata_d = load_data;
                    end
                end else if (fetch_ready) begin
                    state_d = READ;
                    err_d   = fetch_oob;
                    rnw_d   = 1'b1;
                    if (!fetch_oob) begin
                        addr_d = fetch_addr;
                    end
                end
            end
            READ: begin
                if (err_q) begin
                    state_d       = IDLE;
                    fetch_valid_d = 1'b1;
                    addr_err_d    = 1'b1;
                    instr_d       = '0;
                    err_d         = 1'b0;
                end else begin
                    state_d = READ_RSP;
                end
            end
            READ_RSP: begin
                state_d       = IDLE;
                fetch_valid_d = 1'b1;
                instr_d       = iram_data;
            end
            WRITE: begin
                state_d = IDLE;
                rnw_d   = 1'b1;
                if (err_q) begin
                    addr_err_d = 1'b1;
                end else begin
                    load_done_d = 1'b1;
                end
                err_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rnw_d   = 1'b1;
                err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rnw_q         <= 1'b1;
            wdata_q       <= '0;
            instr_q       <= '0;
            err_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rnw_q         <= rnw_d;
            wdata_q       <= wdata_d;
            instr_q       <= instr_d;
            err_q         <= err_d;
            fetch_valid_q <= fetch_valid_d;
            load_done_q   <= load_done_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Write data goes onto the shared bus only during a genuine write cycle.
    assign iram_data = (state_q == WRITE && !err_q) ? wdata_q : 'z;

    assign iram_address        = addr_q;
    assign iram_read_not_write = rnw_q;
    assign fetch_instr         = instr_q;
    assign fetch_valid         = fetch_valid_q;
    assign load_done           = load_done_q;
    assign addr_err            = addr_err_q;
    assign busy                = (state_q != IDLE);

endmodule
